tt_load_queue: RTL and testbench
================================

Name: tt_load_queue

Overview:
- In-order load queue tracking outstanding scalar and vector loads between the issue stage and writeback.
- Issue allocates one entry per memory op, carrying the packed lq_info_s record; the returned lqid travels with the request in mem_skidbuf_s.mem_lqid.
- Memory responses complete entries out of order; retirement to the register-file writeback is strictly in allocation order.

Parameters:
- DEPTH, 8, entry count; power of two, at least 2; matches LQ_DEPTH.
- DATA_W, 256, response data width; matches VLEN.
- INFO_W, 77, packed width of lq_info_s.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_flush  in  1  discard all entries
- i_alloc_valid  in  1  issue requests an entry
- i_alloc_info  in  INFO_W  lq_info_s for the new entry
- o_alloc_ready  out  1  entry available
- o_alloc_lqid  out  log2(DEPTH)  id granted on alloc handshake
- i_resp_valid  in  1  memory response valid
- i_resp_lqid  in  log2(DEPTH)  entry id the response targets
- i_resp_data  in  DATA_W  load data
- o_resp_err  out  1  one-cycle pulse: response hit a non-PENDING entry
- o_ret_valid  out  1  head entry complete
- i_ret_ready  in  1  writeback accepts head
- o_ret_info  out  INFO_W  head entry info
- o_ret_data  out  DATA_W  head entry data
- o_ret_lqid  out  log2(DEPTH)  head entry id
- o_count  out  log2(DEPTH)+1  occupied entries
- o_empty  out  1  count == 0
- o_full  out  1  count == DEPTH

Behaviour:
- Reset is asynchronous, active-low, one clock i_clk.
  - All entries go to FREE; wr_ptr and rd_ptr go to 0.
  - Outputs at reset: o_count=0, o_empty=1, o_full=0, o_alloc_ready=1, o_ret_valid=0, o_resp_err=0, o_alloc_lqid=0, o_ret_lqid=0.
  - o_ret_info and o_ret_data reset to 0.
- Pointers are log2(DEPTH)+1 bits wide; the extra bit is a wrap bit.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
  - Index wraps DEPTH-1 -> 0.
- Per-entry states:
  - FREE -> PENDING on allocate, when info.load | info.vec_load.
  - FREE -> DONE on allocate, for a non-load or when info.vl_is_zero; data stored as 0.
  - PENDING -> DONE on a matching response; data captured.
  - DONE -> FREE on retire.
- Allocate:
  - Fires on i_alloc_valid & o_alloc_ready.
  - o_alloc_ready = !o_full & !i_flush.
  - o_alloc_lqid = wr_ptr index; it is valid combinationally in the handshake cycle.
  - No same-cycle bypass: a full queue does not accept an allocate even if the head retires that cycle.
- Response:
  - When the targeted entry is PENDING, it becomes DONE at the next edge.
  - When the targeted entry is FREE or DONE, no state changes and o_resp_err pulses one cycle later.
  - At most one response per cycle.
- Retire:
  - o_ret_valid = head entry DONE and queue not empty.
  - All o_ret_* outputs come from registered state only, with no combinational path from i_resp_*.
  - A response to the head in cycle N gives o_ret_valid in N+1.
  - On i_ret_ready & o_ret_valid, the head goes FREE and rd_ptr advances.
  - o_ret_info and o_ret_data hold stable while o_ret_valid=1 and i_ret_ready=0.
- Simultaneous events:
  - Allocate and retire in the same cycle: o_count unchanged.
  - A response and a retire of different entries both take effect.
  - A response to an entry allocated in the same cycle is invalid: the entry is still FREE, so o_resp_err fires.
- Flush:
  - At the next edge, all entries go FREE, pointers go to 0 and o_count goes to 0.
  - Flush wins over an allocate, response or retire in the same cycle: none takes effect and o_resp_err is not raised.
  - A response arriving after a flush, for a dropped id, raises o_resp_err.
- Reset asserted mid-operation: immediate asynchronous clear to reset values; in-flight responses are lost.

Test Plan:
- Reset, then allocate 8 loads (info.load=1) -> lqids 0..7; o_full=1 and o_alloc_ready=0 after the 8th; o_ret_valid=0.
- Respond to ids 3, 1, 0 (data 0xA3, 0xA1, 0xA0) with i_ret_ready=1 -> retires id0 (0xA0), then id1 (0xA1), then stalls; id3 retires only after id2 responds.
- Allocate a store (load=0, vec_load=0) into an empty queue -> o_ret_valid=1 on the next cycle with o_ret_data=0 and no response needed.
- Full queue with head DONE, i_alloc_valid=1 and i_ret_ready=1 in the same cycle -> retire occurs, alloc does not, o_count 8->7; the next cycle alloc is granted lqid 0 (wrap).
- 4 entries pending, i_flush=1 with a simultaneous response to id 2 -> o_count=0 and no o_resp_err; a later response to id 2 -> o_resp_err pulse, queue unchanged.
- Deassert i_reset_n mid-stream with 5 entries and o_ret_valid=1 -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/tt_load_queue_if.sv
// Issue / memory-response / writeback bus of the load queue.
// The master modport is the pipeline side, the slave modport is the queue itself.
interface tt_load_queue_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 256,
    parameter int INFO_W = 77
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              i_flush;
    logic              i_alloc_valid;
    logic [INFO_W-1:0] i_alloc_info;
    logic              o_alloc_ready;
    logic [IDX_W-1:0]  o_alloc_lqid;
    logic              i_resp_valid;
    logic [IDX_W-1:0]  i_resp_lqid;
    logic [DATA_W-1:0] i_resp_data;
    logic              o_resp_err;
    logic              o_ret_valid;
    logic              i_ret_ready;
    logic [INFO_W-1:0] o_ret_info;
    logic [DATA_W-1:0] o_ret_data;
    logic [IDX_W-1:0]  o_ret_lqid;
    logic [IDX_W:0]    o_count;
    logic              o_empty;
    logic              o_full;

    modport master (
        output i_flush, i_alloc_valid, i_alloc_info, i_resp_valid, i_resp_lqid,
               i_resp_data, i_ret_ready,
        input  o_alloc_ready, o_alloc_lqid, o_resp_err, o_ret_valid, o_ret_info,
               o_ret_data, o_ret_lqid, o_count, o_empty, o_full
    );

    modport slave (
        input  i_flush, i_alloc_valid, i_alloc_info, i_resp_valid, i_resp_lqid,
               i_resp_data, i_ret_ready,
        output o_alloc_ready, o_alloc_lqid, o_resp_err, o_ret_valid, o_ret_info,
               o_ret_data, o_ret_lqid, o_count, o_empty, o_full
    );
endinterface

// File: rtl/tt_load_queue.sv
// In-order load queue: entries are allocated at issue, completed out of order by
// memory responses, and retired to writeback strictly in allocation order.
module tt_load_queue #(
    parameter int DEPTH        = 8,
    parameter int DATA_W       = 256,
    parameter int INFO_W       = 77,
    parameter int LOAD_BIT     = 0,
    parameter int VEC_LOAD_BIT = 1,
    parameter int VL_ZERO_BIT  = 2
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    tt_load_queue_if.slave lq
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]        state_q [DEPTH];
    logic [1:0]        state_d [DEPTH];
    logic [INFO_W-1:0] info_q  [DEPTH];
    logic [INFO_W-1:0] info_d  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              resp_err_q, resp_err_d;

    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              empty, full, alloc_ready, alloc_fire, alloc_pending;
    logic              ret_valid, ret_fire;

    assign wr_idx        = wr_ptr_q[IDX_W-1:0];
    assign rd_idx        = rd_ptr_q[IDX_W-1:0];
    assign empty         = (wr_ptr_q == rd_ptr_q);
    assign full          = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign alloc_ready   = !full && !lq.i_flush;
    assign alloc_fire    = lq.i_alloc_valid && alloc_ready;
    assign alloc_pending = (lq.i_alloc_info[LOAD_BIT] || lq.i_alloc_info[VEC_LOAD_BIT])
                           && !lq.i_alloc_info[VL_ZERO_BIT];
    assign ret_valid     = !empty && (state_q[rd_idx] == ST_DONE);
    assign ret_fire      = ret_valid && lq.i_ret_ready;

    // Allocate, respond and retire always touch distinct entries (FREE, PENDING
    // and DONE respectively), so their updates never collide.
    always_comb begin
        state_d    = state_q;
        info_d     = info_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        resp_err_d = 1'b0;
        if (lq.i_flush) begin
            for (int i = 0; i < DEPTH; i++) state_d[i] = ST_FREE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (alloc_fire) begin
                state_d[wr_idx] = alloc_pending ? ST_PENDING : ST_DONE;
                info_d[wr_idx]  = lq.i_alloc_info;
                data_d[wr_idx]  = '0;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (lq.i_resp_valid) begin
                if (state_q[lq.i_resp_lqid] == ST_PENDING) begin
                    state_d[lq.i_resp_lqid] = ST_DONE;
                    data_d[lq.i_resp_lqid]  = lq.i_resp_data;
                end else begin
                    resp_err_d = 1'b1;
                end
            end
            if (ret_fire) begin
                state_d[rd_idx] = ST_FREE;
                rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Payload storage needs no reset: it is only visible through a DONE head.
    always_ff @(posedge i_clk) begin
        info_q <= info_d;
        data_q <= data_d;
    end

    assign lq.o_alloc_ready = alloc_ready;
    assign lq.o_alloc_lqid  = wr_idx;
    assign lq.o_resp_err    = resp_err_q;
    assign lq.o_ret_valid   = ret_valid;
    assign lq.o_ret_lqid    = rd_idx;
    assign lq.o_ret_info    = ret_valid ? info_q[rd_idx] : '0;
    assign lq.o_ret_data    = ret_valid ? data_q[rd_idx] : '0;
    assign lq.o_count       = wr_ptr_q - rd_ptr_q;
    assign lq.o_empty       = empty;
    assign lq.o_full        = full;
endmodule

// File: tb/tb_tt_load_queue.sv
// Directed scoreboard bench for tt_load_queue: stimulus queues expected retires and
// response errors, independent monitors pop and compare them as the DUT presents them.
module tb_tt_load_queue;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 256;
    localparam int INFO_W = 77;

    localparam logic [2:0] F_STORE = 3'b000;
    localparam logic [2:0] F_LOAD  = 3'b001;
    localparam logic [2:0] F_VLZ   = 3'b100;

    typedef struct {
        logic [2:0]        lqid;
        logic [DATA_W-1:0] data;
        logic [INFO_W-1:0] info;
    } ret_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    ret_t exp_ret[$];
    int   exp_err_q[$];

    tt_load_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .INFO_W(INFO_W)) lq_if ();

    tt_load_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .INFO_W(INFO_W)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .lq        (lq_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [INFO_W-1:0] mk(input int tag, input logic [2:0] flags);
        return (INFO_W'(tag) << 8) | INFO_W'(flags);
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, then waits to mid-cycle.
    task automatic applyStimulus(input logic alloc_v, input logic [INFO_W-1:0] info,
                                 input logic resp_v, input logic [2:0] resp_id,
                                 input logic [DATA_W-1:0] resp_data,
                                 input logic ret_rdy, input logic flush);
        @(posedge clk);
        #1;
        lq_if.i_alloc_valid = alloc_v;
        lq_if.i_alloc_info  = info;
        lq_if.i_resp_valid  = resp_v;
        lq_if.i_resp_lqid   = resp_id;
        lq_if.i_resp_data   = resp_data;
        lq_if.i_ret_ready   = ret_rdy;
        lq_if.i_flush       = flush;
        @(negedge clk);
    endtask

    task automatic idle(input logic ret_rdy);
        applyStimulus(1'b0, '0, 1'b0, 3'd0, '0, ret_rdy, 1'b0);
    endtask

    task automatic expectRet(input logic [2:0] id, input logic [DATA_W-1:0] d,
                             input logic [INFO_W-1:0] inf);
        exp_ret.push_back('{id, d, inf});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_count"},       256'(lq_if.o_count),       256'(0));
        checkOutput({tag, "_empty"},       256'(lq_if.o_empty),       256'(1));
        checkOutput({tag, "_full"},        256'(lq_if.o_full),        256'(0));
        checkOutput({tag, "_alloc_ready"}, 256'(lq_if.o_alloc_ready), 256'(1));
        checkOutput({tag, "_ret_valid"},   256'(lq_if.o_ret_valid),   256'(0));
        checkOutput({tag, "_resp_err"},    256'(lq_if.o_resp_err),    256'(0));
        checkOutput({tag, "_alloc_lqid"},  256'(lq_if.o_alloc_lqid),  256'(0));
        checkOutput({tag, "_ret_lqid"},    256'(lq_if.o_ret_lqid),    256'(0));
        checkOutput({tag, "_ret_info"},    256'(lq_if.o_ret_info),    256'(0));
        checkOutput({tag, "_ret_data"},    256'(lq_if.o_ret_data),    256'(0));
    endtask

    // Retire monitor: every accepted head must match the next expected record.
    initial begin : ret_monitor
        ret_t e;
        forever begin
            @(negedge clk);
            if (rst_n && lq_if.o_ret_valid && lq_if.i_ret_ready) begin
                if (exp_ret.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_retire: got lqid %0d, required no retire",
                             lq_if.o_ret_lqid);
                end else begin
                    e = exp_ret.pop_front();
                    checkOutput("ret_lqid", 256'(lq_if.o_ret_lqid), 256'(e.lqid));
                    checkOutput("ret_data", 256'(lq_if.o_ret_data), 256'(e.data));
                    checkOutput("ret_info", 256'(lq_if.o_ret_info), 256'(e.info));
                end
            end
        end
    end

    // Error monitor: each o_resp_err pulse must land on the expected cycle.
    initial begin : err_monitor
        int e;
        forever begin
            @(negedge clk);
            if (rst_n && lq_if.o_resp_err) begin
                if (exp_err_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_resp_err: got pulse at cycle %0d, required none", cyc);
                end else begin
                    e = exp_err_q.pop_front();
                    checkOutput("resp_err_cycle", 256'(cyc), 256'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n               = 1'b0;
        lq_if.i_flush       = 1'b0;
        lq_if.i_alloc_valid = 1'b0;
        lq_if.i_alloc_info  = '0;
        lq_if.i_resp_valid  = 1'b0;
        lq_if.i_resp_lqid   = '0;
        lq_if.i_resp_data   = '0;
        lq_if.i_ret_ready   = 1'b0;
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] fill with 8 loads");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, mk(i, F_LOAD), 1'b0, 3'd0, '0, 1'b0, 1'b0);
            checkOutput("fill_alloc_lqid", 256'(lq_if.o_alloc_lqid), 256'(i));
            checkOutput("fill_alloc_ready", 256'(lq_if.o_alloc_ready), 256'(1));
        end
        idle(1'b0);
        checkOutput("full_count", 256'(lq_if.o_count), 256'(8));
        checkOutput("full_flag", 256'(lq_if.o_full), 256'(1));
        checkOutput("full_alloc_ready", 256'(lq_if.o_alloc_ready), 256'(0));
        checkOutput("full_ret_valid", 256'(lq_if.o_ret_valid), 256'(0));

        $display("[TB] out-of-order responses, in-order retire");
        applyStimulus(1'b0, '0, 1'b1, 3'd3, 256'hA3, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 3'd1, 256'hA1, 1'b1, 1'b0);
        checkOutput("head_not_done", 256'(lq_if.o_ret_valid), 256'(0));
        applyStimulus(1'b0, '0, 1'b1, 3'd0, 256'hA0, 1'b1, 1'b0);
        expectRet(3'd0, 256'hA0, mk(0, F_LOAD));
        expectRet(3'd1, 256'hA1, mk(1, F_LOAD));
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("stall_ret_valid", 256'(lq_if.o_ret_valid), 256'(0));
        checkOutput("stall_ret_lqid", 256'(lq_if.o_ret_lqid), 256'(2));
        checkOutput("stall_count", 256'(lq_if.o_count), 256'(6));
        applyStimulus(1'b0, '0, 1'b1, 3'd2, 256'hA2, 1'b1, 1'b0);
        expectRet(3'd2, 256'hA2, mk(2, F_LOAD));
        expectRet(3'd3, 256'hA3, mk(3, F_LOAD));
        idle(1'b1);
        idle(1'b1);
        for (int k = 4; k < DEPTH; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 3'(k), 256'(32'hA0 + k), 1'b1, 1'b0);
            expectRet(3'(k), 256'(32'hA0 + k), mk(k, F_LOAD));
            if (k == 4) checkOutput("drain_count", 256'(lq_if.o_count), 256'(4));
        end
        idle(1'b1);
        idle(1'b0);
        checkOutput("drained_count", 256'(lq_if.o_count), 256'(0));
        checkOutput("drained_empty", 256'(lq_if.o_empty), 256'(1));

        $display("[TB] non-load and zero-length entries complete at allocate");
        applyStimulus(1'b1, mk(20, F_STORE), 1'b0, 3'd0, '0, 1'b0, 1'b0);
        checkOutput("store_alloc_lqid", 256'(lq_if.o_alloc_lqid), 256'(0));
        applyStimulus(1'b1, mk(21, F_LOAD | F_VLZ), 1'b0, 3'd0, '0, 1'b0, 1'b0);
        checkOutput("store_alloc_lqid2", 256'(lq_if.o_alloc_lqid), 256'(1));
        checkOutput("store_ret_valid", 256'(lq_if.o_ret_valid), 256'(1));
        checkOutput("store_ret_data", 256'(lq_if.o_ret_data), 256'(0));
        idle(1'b0);
        checkOutput("hold_ret_valid", 256'(lq_if.o_ret_valid), 256'(1));
        checkOutput("hold_ret_info", 256'(lq_if.o_ret_info), 256'(mk(20, F_STORE)));
        checkOutput("hold_count", 256'(lq_if.o_count), 256'(2));
        expectRet(3'd0, '0, mk(20, F_STORE));
        expectRet(3'd1, '0, mk(21, F_LOAD | F_VLZ));
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        checkOutput("store_empty", 256'(lq_if.o_empty), 256'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] full queue: retire wins, allocate waits one cycle");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, mk(30 + i, F_LOAD), 1'b0, 3'd0, '0, 1'b0, 1'b0);
            checkOutput("refill_alloc_lqid", 256'(lq_if.o_alloc_lqid), 256'(i));
        end
        applyStimulus(1'b0, '0, 1'b1, 3'd0, 256'hC0, 1'b0, 1'b0);
        expectRet(3'd0, 256'hC0, mk(30, F_LOAD));
        applyStimulus(1'b1, mk(40, F_LOAD), 1'b0, 3'd0, '0, 1'b1, 1'b0);
        checkOutput("nobypass_alloc_ready", 256'(lq_if.o_alloc_ready), 256'(0));
        checkOutput("nobypass_ret_valid", 256'(lq_if.o_ret_valid), 256'(1));
        applyStimulus(1'b1, mk(41, F_LOAD), 1'b0, 3'd0, '0, 1'b0, 1'b0);
        checkOutput("after_retire_count", 256'(lq_if.o_count), 256'(7));
        checkOutput("wrap_alloc_ready", 256'(lq_if.o_alloc_ready), 256'(1));
        checkOutput("wrap_alloc_lqid", 256'(lq_if.o_alloc_lqid), 256'(0));
        idle(1'b0);
        checkOutput("refull_count", 256'(lq_if.o_count), 256'(8));
        checkOutput("refull_flag", 256'(lq_if.o_full), 256'(1));

        $display("[TB] flush beats response, stale response errors");
        applyStimulus(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("flush_count", 256'(lq_if.o_count), 256'(0));
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, mk(50 + i, F_LOAD), 1'b0, 3'd0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, mk(60, F_LOAD), 1'b1, 3'd2, 256'hD2, 1'b0, 1'b1);
        checkOutput("flush_alloc_ready", 256'(lq_if.o_alloc_ready), 256'(0));
        idle(1'b0);
        checkOutput("flush2_count", 256'(lq_if.o_count), 256'(0));
        checkOutput("flush2_empty", 256'(lq_if.o_empty), 256'(1));
        checkOutput("flush2_resp_err", 256'(lq_if.o_resp_err), 256'(0));
        checkOutput("flush2_alloc_lqid", 256'(lq_if.o_alloc_lqid), 256'(0));
        applyStimulus(1'b0, '0, 1'b1, 3'd2, 256'hD2, 1'b0, 1'b0);
        exp_err_q.push_back(cyc + 1);
        idle(1'b0);
        checkOutput("stale_resp_err", 256'(lq_if.o_resp_err), 256'(1));
        checkOutput("stale_count", 256'(lq_if.o_count), 256'(0));

        $display("[TB] response to an entry allocated the same cycle");
        applyStimulus(1'b1, mk(70, F_LOAD), 1'b1, 3'd0, 256'hEE, 1'b0, 1'b0);
        exp_err_q.push_back(cyc + 1);
        checkOutput("same_cycle_lqid", 256'(lq_if.o_alloc_lqid), 256'(0));
        idle(1'b0);
        checkOutput("same_cycle_count", 256'(lq_if.o_count), 256'(1));
        checkOutput("same_cycle_ret_valid", 256'(lq_if.o_ret_valid), 256'(0));
        applyStimulus(1'b0, '0, 1'b1, 3'd0, 256'hB0, 1'b0, 1'b0);
        expectRet(3'd0, 256'hB0, mk(70, F_LOAD));
        idle(1'b1);
        idle(1'b0);
        checkOutput("same_cycle_drain", 256'(lq_if.o_count), 256'(0));

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, mk(80 + i, F_STORE), 1'b0, 3'd0, '0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("pre_reset_count", 256'(lq_if.o_count), 256'(5));
        checkOutput("pre_reset_ret_valid", 256'(lq_if.o_ret_valid), 256'(1));
        checkOutput("pre_reset_ret_lqid", 256'(lq_if.o_ret_lqid), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        checkOutput("post_reset_count", 256'(lq_if.o_count), 256'(0));

        idle(1'b0);
        checkOutput("ret_scoreboard_drained", 256'(exp_ret.size()), 256'(0));
        checkOutput("err_scoreboard_drained", 256'(exp_err_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
